// File: rtl/axis_i2c_pkg.sv
// Shared widths, default frequencies, FSM state type and the per-state SCL/SDA waveform decode.
package axis_i2c_pkg;
    localparam int I2C_DATA_WIDTH  = 8;
    localparam int AXIS_DATA_WIDTH = 16;
    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_I2C_FREQ_HZ = 100_000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_NACK,
        ST_STOP
    } state_e;

    // Bit slots: SCL low in q0/q1, high in q2/q3.
    function automatic logic scl_level(input state_e st, input logic [1:0] qtr);
        case (st)
            ST_IDLE:  scl_level = 1'b1;
            ST_START: scl_level = (qtr != 2'd3);
            ST_STOP:  scl_level = (qtr != 2'd0);
            default:  scl_level = qtr[1];
        endcase
    endfunction

    function automatic logic sda_pull_low(input state_e st, input logic [1:0] qtr, input logic bit_val);
        case (st)
            ST_START:            sda_pull_low = (qtr != 2'd0);
            ST_STOP:             sda_pull_low = !qtr[1];
            ST_ADDR, ST_WR_DATA: sda_pull_low = !bit_val;
            default:             sda_pull_low = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream beat channel: tvalid/tready handshake carrying one command word.
interface axis_if;
    import axis_i2c_pkg::*;
    logic                       tvalid;
    logic                       tready;
    logic [AXIS_DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-bit tick generator: one-cycle tick every DIV clocks while enabled, counter held at 0 otherwise.
// No backpressure; tick_o is combinational from the counter state.
module i2c_clk_div #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int DIV_C = (DIV < 1) ? 1 : DIV;
    localparam int CW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == CW'(DIV_C - 1));
        cnt_d  = cnt_q + 1'b1;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/axis_i2c_master.sv
// AXI-Stream commanded single-byte I2C master; a command occupies 80 quarter ticks (44 on address NACK).
// tready is high only in IDLE, so a pending beat simply waits for the current transaction to finish.
module axis_i2c_master
    import axis_i2c_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int I2C_FREQ_HZ = DEF_I2C_FREQ_HZ
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    axis_if.slave                     s_axis,
    output logic                      i2c_scl_o,
    inout  wire                       i2c_sda_io,
    output logic [I2C_DATA_WIDTH-1:0] i2c_rdata_o,
    output logic                      rvalid_o
);
    localparam int DIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);

    state_e                    state_q, state_d;
    logic [1:0]                qtr_q, qtr_d;
    logic [2:0]                bit_q, bit_d;
    logic [7:0]                sh_q, sh_d;
    logic [7:0]                wr_q, wr_d;
    logic [I2C_DATA_WIDTH-1:0] rd_q, rd_d;
    logic [I2C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rw_q, rw_d;
    logic                      ack_q, ack_d;
    logic                      rvalid_q, rvalid_d;
    logic                      scl_q, scl_d;
    logic                      sda_low_q, sda_low_d;
    logic                      rdy_q;
    logic                      tick;
    logic                      sda_in;

    i2c_clk_div #(.DIV(DIV)) u_clk_div (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (state_q != ST_IDLE),
        .tick_o  (tick)
    );

    assign sda_in         = i2c_sda_io;
    assign i2c_sda_io     = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_scl_o      = scl_q;
    assign i2c_rdata_o    = rdata_q;
    assign rvalid_o       = rvalid_q;
    // rdy_q keeps tready low through reset and for the first clock after release.
    assign s_axis.tready  = rdy_q && (state_q == ST_IDLE);

    always_comb begin
        state_d  = state_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        rvalid_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (s_axis.tvalid && s_axis.tready) begin
                state_d = ST_START;
                qtr_d   = 2'd0;
                bit_d   = 3'd0;
                sh_d    = s_axis.tdata[15:8];
                rw_d    = s_axis.tdata[8];
                wr_d    = s_axis.tdata[7:0];
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd2 && state_q == ST_RD_DATA)  rd_d  = {rd_q[I2C_DATA_WIDTH-2:0], sda_in};
            if (qtr_q == 2'd2 && state_q == ST_ADDR_ACK) ack_d = sda_in;
            if (qtr_q == 2'd3) begin
                case (state_q)
                    ST_START: state_d = ST_ADDR;
                    ST_ADDR, ST_WR_DATA: begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                    end
                    ST_ADDR_ACK: begin
                        if (ack_q) begin
                            state_d = ST_STOP;
                        end else if (rw_q) begin
                            state_d = ST_RD_DATA;
                        end else begin
                            state_d = ST_WR_DATA;
                            sh_d    = wr_q;
                        end
                    end
                    ST_WR_ACK: state_d = ST_STOP;
                    ST_RD_DATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ST_RD_NACK;
                    end
                    ST_RD_NACK: begin
                        rdata_d  = rd_q;
                        rvalid_d = 1'b1;
                        state_d  = ST_STOP;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
        // Pins are registered from the next state so they change cleanly on the clock edge.
        scl_d     = scl_level(state_d, qtr_d);
        sda_low_d = sda_pull_low(state_d, qtr_d, sh_d[7]);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= ST_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            sh_q      <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            rvalid_q  <= rvalid_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            rdy_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_i2c_master.sv
// Directed bench: protocol-level I2C slave/monitor on the pins, table of commands, plus reset and back-to-back sequences.
module tb_axis_i2c_master;
    logic       clk = 1'b0;
    logic       arstn;
    logic       scl;
    logic [7:0] rdata;
    logic       rvalid;
    wire        sda_bus;

    axis_if s_axis_bus ();

    axis_i2c_master #(.CLK_FREQ_HZ(400_000), .I2C_FREQ_HZ(100_000)) dut (
        .clk_i       (clk),
        .arstn_i     (arstn),
        .s_axis      (s_axis_bus),
        .i2c_scl_o   (scl),
        .i2c_sda_io  (sda_bus),
        .i2c_rdata_o (rdata),
        .rvalid_o    (rvalid)
    );

    always #5 clk = ~clk;

    logic slv_low = 1'b0;
    logic slv_ack = 1'b0;
    logic [7:0] slv_rd = 8'h00;
    assign sda_bus = slv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor and slave model, evaluated on the falling clock edge.
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         rises = 0, starts = 0, stops = 0, rv_cnt = 0, od_viol = 0;
    logic [7:0] b0 = 8'h00, b1 = 8'h00;
    logic       ack1 = 1'b0, ack2 = 1'b0;

    always @(negedge clk) begin
        logic scl_n, sda_n;
        scl_n = scl;
        sda_n = sda_bus;
        if (rvalid) rv_cnt++;
        if (slv_low && sda_n !== 1'b0) od_viol++;
        if (scl_p && scl_n && sda_p && !sda_n) begin
            starts++;
            rises = 0;
            slv_low = 1'b0;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
            stops++;
        end else if (!scl_p && scl_n) begin
            if (rises < 8)       b0 = {b0[6:0], sda_n};
            else if (rises == 8) ack1 = sda_n;
            else if (rises < 17) b1 = {b1[6:0], sda_n};
            else if (rises == 17) ack2 = sda_n;
            rises++;
        end else if (scl_p && !scl_n) begin
            slv_low = 1'b0;
            if (rises == 8) slv_low = slv_ack;
            else if (slv_ack && b0[0] && rises >= 9 && rises <= 16) slv_low = !slv_rd[16-rises];
            else if (slv_ack && !b0[0] && rises == 17) slv_low = 1'b1;
        end
        scl_p = scl_n;
        sda_p = sda_n;
    end

    task automatic send(input logic [15:0] d, output int cyc);
        int guard;
        guard = 0;
        while (!s_axis_bus.tready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        starts = 0;
        stops  = 0;
        rv_cnt = 0;
        s_axis_bus.tvalid = 1'b1;
        s_axis_bus.tdata  = d;
        @(negedge clk);
        s_axis_bus.tvalid = 1'b0;
        cyc = 0;
        while (!s_axis_bus.tready && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] tdata;
        logic        ack;
        logic [7:0]  rd;
        int          cycles;
        int          rises;
        logic [7:0]  b0;
        logic        ack1;
        logic [7:0]  b1;
        logic        ack2;
        int          rv;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, cyc2;
        vecs[0] = '{16'hA0A5, 1'b1, 8'h00, 80, 19, 8'hA0, 1'b0, 8'hA5, 1'b0, 0, 8'h00};
        vecs[1] = '{16'hA100, 1'b1, 8'h3C, 80, 19, 8'hA1, 1'b0, 8'h3C, 1'b1, 1, 8'h3C};
        vecs[2] = '{16'hA100, 1'b0, 8'h3C, 44, 10, 8'hA1, 1'b1, 8'h00, 1'b0, 0, 8'h3C};
        vecs[3] = '{16'h5A12, 1'b1, 8'h00, 80, 19, 8'h5A, 1'b0, 8'h12, 1'b0, 0, 8'h3C};
        vecs[4] = '{16'h4F00, 1'b1, 8'hC5, 80, 19, 8'h4F, 1'b0, 8'hC5, 1'b1, 1, 8'hC5};
        vecs[5] = '{16'h3000, 1'b0, 8'h00, 44, 10, 8'h30, 1'b1, 8'h00, 1'b0, 0, 8'hC5};

        arstn = 1'b0;
        s_axis_bus.tvalid = 1'b0;
        s_axis_bus.tdata  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_scl", scl, 1);
        chk("reset_sda", sda_bus, 1);
        chk("reset_tready", s_axis_bus.tready, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        arstn = 1'b1;
        #1;
        chk("tready_at_release", s_axis_bus.tready, 0);
        @(negedge clk);
        chk("tready_first_clock", s_axis_bus.tready, 1);

        for (int i = 0; i < 6; i++) begin
            slv_ack = vecs[i].ack;
            slv_rd  = vecs[i].rd;
            send(vecs[i].tdata, cyc);
            chk($sformatf("v%0d_ticks", i), cyc, vecs[i].cycles);
            chk($sformatf("v%0d_starts", i), starts, 1);
            chk($sformatf("v%0d_stops", i), stops, 1);
            chk($sformatf("v%0d_scl_rises", i), rises, vecs[i].rises);
            chk($sformatf("v%0d_byte0", i), b0, vecs[i].b0);
            chk($sformatf("v%0d_ack1", i), ack1, vecs[i].ack1);
            if (vecs[i].rises == 19) begin
                chk($sformatf("v%0d_byte1", i), b1, vecs[i].b1);
                chk($sformatf("v%0d_ack2", i), ack2, vecs[i].ack2);
            end
            chk($sformatf("v%0d_rvalid_pulses", i), rv_cnt, vecs[i].rv);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
        end

        // Back-to-back: tvalid stays high across both commands.
        slv_ack = 1'b1;
        starts = 0;
        stops  = 0;
        s_axis_bus.tvalid = 1'b1;
        s_axis_bus.tdata  = 16'hA011;
        @(negedge clk);
        s_axis_bus.tdata  = 16'hA022;
        cyc = 0;
        while (!s_axis_bus.tready && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        chk("b2b_first_ticks", cyc, 80);
        chk("b2b_first_byte1", b1, 8'h11);
        @(negedge clk);
        s_axis_bus.tvalid = 1'b0;
        cyc2 = 0;
        while (!s_axis_bus.tready && cyc2 < 2000) begin
            cyc2++;
            @(negedge clk);
        end
        chk("b2b_second_ticks", cyc2, 80);
        chk("b2b_second_byte1", b1, 8'h22);
        chk("b2b_starts", starts, 2);
        chk("b2b_stops", stops, 2);
        repeat (5) @(negedge clk);
        chk("b2b_no_third", starts, 2);

        // Reset during the address byte (bit 2, SCL low).
        starts = 0;
        stops  = 0;
        s_axis_bus.tvalid = 1'b1;
        s_axis_bus.tdata  = 16'hA0A5;
        @(negedge clk);
        s_axis_bus.tvalid = 1'b0;
        repeat (12) @(negedge clk);
        chk("midreset_scl_before", scl, 0);
        arstn = 1'b0;
        #1;
        chk("midreset_scl", scl, 1);
        chk("midreset_sda", sda_bus, 1);
        chk("midreset_tready", s_axis_bus.tready, 0);
        chk("midreset_rdata", rdata, 0);
        repeat (3) @(negedge clk);
        chk("midreset_no_stop", stops, 0);
        arstn = 1'b1;
        @(negedge clk);
        chk("midreset_tready_back", s_axis_bus.tready, 1);
        send(16'hA0A5, cyc);
        chk("after_reset_ticks", cyc, 80);
        chk("after_reset_byte0", b0, 8'hA0);
        chk("after_reset_byte1", b1, 8'hA5);
        chk("after_reset_stops", stops, 1);
        chk("after_reset_rvalid", rv_cnt, 0);

        chk("open_drain", od_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
